// File: rtl/ifu_pkg.sv
// Shared instruction-fetch constants and the fetch packet type.
package ifu_pkg;

   localparam int unsigned IBUF_DEPTH  = 8;
   localparam int unsigned FETCH_WIDTH = 4;
   localparam int unsigned INST_W      = 32;

   typedef struct packed {
      logic [2:0]                         cnt;
      logic [FETCH_WIDTH-1:0][INST_W-1:0] data;
   } fetch_pkt_t;

endpackage

// File: rtl/ifu_ibuf_popcnt.sv
// Counts the leading run of lanes, starting at lane A, that complete a handshake.
module ifu_ibuf_popcnt (
   input  logic [3:0] valid,
   input  logic [3:0] allow_in,
   output logic [2:0] pop_cnt
);

   logic run;

   always_comb begin
      pop_cnt = 3'd0;
      run     = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (run && valid[k] && allow_in[k]) begin
            pop_cnt = pop_cnt + 3'd1;
         end else begin
            run = 1'b0;
         end
      end
   end

endmodule

// File: rtl/ifu_ibuf.sv
// Instruction buffer: circular FIFO accepting up to four instructions per packet
// and presenting the four oldest entries on in-order issue lanes A..D.
module ifu_ibuf
   import ifu_pkg::*;
#(
   parameter int unsigned IBUF_DEPTH  = ifu_pkg::IBUF_DEPTH,
   parameter int unsigned FETCH_WIDTH = ifu_pkg::FETCH_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          fetch_valid,
   output logic          fetch_ready,
   input  logic [2:0]    fetch_cnt,
   input  logic [127:0]  fetch_data,
   output logic          ifu_instA_valid,
   output logic          ifu_instB_valid,
   output logic          ifu_instC_valid,
   output logic          ifu_instD_valid,
   input  logic          ifu_instA_allowIn,
   input  logic          ifu_instB_allowIn,
   input  logic          ifu_instC_allowIn,
   input  logic          ifu_instD_allowIn,
   output logic [31:0]   ifu_instA_data,
   output logic [31:0]   ifu_instB_data,
   output logic [31:0]   ifu_instC_data,
   output logic [31:0]   ifu_instD_data
);

   localparam int unsigned PTR_W = $clog2(IBUF_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [INST_W-1:0] mem_q [IBUF_DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   fetch_pkt_t        pkt;
   logic              push;
   logic [2:0]        push_cnt;
   logic [2:0]        pop_cnt;
   logic [3:0]        lane_valid;
   logic [3:0]        lane_allow;
   logic [INST_W-1:0] lane_data [4];

   assign pkt.cnt  = fetch_cnt;
   assign pkt.data = fetch_data;

   // Lanes are driven from registered state only; no bypass from the fetch port.
   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign lane_valid[k] = count_q > CNT_W'(k);
      assign lane_data[k]  = mem_q[head_q + PTR_W'(k)];
   end

   assign lane_allow = {ifu_instD_allowIn, ifu_instC_allowIn,
                        ifu_instB_allowIn, ifu_instA_allowIn};

   ifu_ibuf_popcnt u_popcnt (
      .valid    (lane_valid),
      .allow_in (lane_allow),
      .pop_cnt  (pop_cnt)
   );

   // Same-cycle pops are not credited toward space for the incoming packet.
   assign fetch_ready = count_q <= CNT_W'(IBUF_DEPTH - FETCH_WIDTH);
   assign push        = fetch_valid && fetch_ready;
   assign push_cnt    = push ? pkt.cnt : 3'd0;

   always_comb begin
      head_d  = head_q + PTR_W'(pop_cnt);
      tail_d  = tail_q + PTR_W'(push_cnt);
      count_d = count_q + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry contents are not reset; a flushed or reset buffer simply has count 0.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (push && (3'(i) < pkt.cnt)) begin
            mem_q[tail_q + PTR_W'(i)] <= pkt.data[i];
         end
      end
   end

   assign ifu_instA_valid = lane_valid[0];
   assign ifu_instB_valid = lane_valid[1];
   assign ifu_instC_valid = lane_valid[2];
   assign ifu_instD_valid = lane_valid[3];
   assign ifu_instA_data  = lane_data[0];
   assign ifu_instB_data  = lane_data[1];
   assign ifu_instC_data  = lane_data[2];
   assign ifu_instD_data  = lane_data[3];

endmodule
